// File: rtl/pipelined_carry_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES ripple
// segments with the inter-segment carry registered, valid/ready on both sides.
module pipelined_carry_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Ovf
);

  localparam int SEG = WIDTH / STAGES;

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
    $error("pipelined_carry_adder: WIDTH must be a positive multiple of STAGES");
  end

  // Ripple of SEG full adders; returns {carry into top bit, carry out, sum}.
  function automatic logic [SEG+1:0] seg_add(
    input logic [SEG-1:0] a,
    input logic [SEG-1:0] b,
    input logic           ci
  );
    logic           c;
    logic           ctop;
    logic [SEG-1:0] s;
    c    = ci;
    ctop = ci;
    s    = '0;
    for (int i = 0; i < SEG; i++) begin
      ctop = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {ctop, c, s};
  endfunction

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] adv_s;
  logic [STAGES-1:0] vin_s;
  logic [STAGES-1:0] ld_s;
  logic [STAGES:0]   vin_ext_s;
  logic [STAGES-1:0] ovf_all_s;

  // Valid bit arriving at each stage: input handshake for stage 0, else predecessor.
  assign vin_ext_s = {v_q, in_valid};
  assign vin_s     = vin_ext_s[STAGES-1:0];

  // Ready chain: a stage may load when it is empty or its successor moves on.
  always_comb begin
    adv_s           = '0;
    adv_s[STAGES-1] = ~v_q[STAGES-1] | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv_s[k] = ~v_q[k] | adv_s[k+1];
    end
    v_d  = (adv_s & vin_s) | (~adv_s & v_q);
    ld_s = adv_s & vin_s;
  end

  // Stage occupancy register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             c_q, c_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] src_a_s;
    logic [WIDTH-1:0] src_b_s;
    logic [WIDTH-1:0] src_res_s;
    logic             src_c_s;
    logic [SEG+1:0]   seg_s;

    // Stage 0 takes fresh operands (B inverted and carry forced for subtract).
    if (k == 0) begin : g_src
      assign src_a_s   = A;
      assign src_b_s   = sub ? ~B : B;
      assign src_c_s   = sub ? 1'b1 : cin;
      assign src_res_s = '0;
    end else begin : g_src
      assign src_a_s   = g_stage[k-1].a_q;
      assign src_b_s   = g_stage[k-1].b_q;
      assign src_c_s   = g_stage[k-1].c_q;
      assign src_res_s = g_stage[k-1].res_q;
    end

    // Add this stage's segment and merge it into the partial result.
    always_comb begin
      seg_s               = seg_add(src_a_s[k*SEG +: SEG], src_b_s[k*SEG +: SEG], src_c_s);
      res_d               = src_res_s;
      res_d[k*SEG +: SEG] = seg_s[SEG-1:0];
      a_d                 = src_a_s;
      b_d                 = src_b_s;
      c_d                 = seg_s[SEG];
      ovf_d               = seg_s[SEG+1] ^ seg_s[SEG];
    end

    // Stage data register; holds while stalled or when no operation arrives.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        a_q   <= '0;
        b_q   <= '0;
        res_q <= '0;
        c_q   <= 1'b0;
        ovf_q <= 1'b0;
      end else if (ld_s[k]) begin
        a_q   <= a_d;
        b_q   <= b_d;
        res_q <= res_d;
        c_q   <= c_d;
        ovf_q <= ovf_d;
      end
    end

    assign ovf_all_s[k] = ovf_q;
  end

  // Nothing transfers on either side while reset is asserted.
  assign in_ready  = rst_n & adv_s[0];
  assign out_valid = rst_n & v_q[STAGES-1];
  assign Sum       = g_stage[STAGES-1].res_q;
  assign Carry     = g_stage[STAGES-1].c_q;
  assign Ovf       = ovf_all_s[STAGES-1];

  logic unused_s;
  assign unused_s = ^{vin_ext_s[STAGES], ovf_all_s, g_stage[STAGES-1].a_q, g_stage[STAGES-1].b_q};

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Scoreboard bench for pipelined_carry_adder: directed, random-stream,
// backpressure, reset and parameter-sweep scenarios.
module tb_pipelined_carry_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] A, B, Sum;
  logic        cin, sub, Carry, Ovf;

  logic        sw_cin, sw_sub, sw_ordy;
  logic        s1_iv, s1_ir, s1_ov, s1_c, s1_o;
  logic [15:0] s1_a, s1_b, s1_s;
  logic        s16_iv, s16_ir, s16_ov, s16_c, s16_o;
  logic [15:0] s16_a, s16_b, s16_s;
  logic        s8_iv, s8_ir, s8_ov, s8_c, s8_o;
  logic [7:0]  s8_a, s8_b, s8_s;

  int checks = 0;
  int errors = 0;

  logic [33:0] sb_q[$];
  logic        stall_q;
  logic [33:0] stall_val;

  pipelined_carry_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Carry(Carry), .Ovf(Ovf)
  );

  pipelined_carry_adder #(.WIDTH(16), .STAGES(1)) u16x1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s1_iv), .in_ready(s1_ir),
    .A(s1_a), .B(s1_b), .cin(sw_cin), .sub(sw_sub), .out_valid(s1_ov), .out_ready(sw_ordy),
    .Sum(s1_s), .Carry(s1_c), .Ovf(s1_o)
  );

  pipelined_carry_adder #(.WIDTH(16), .STAGES(16)) u16x16 (
    .clk(clk), .rst_n(rst_n), .in_valid(s16_iv), .in_ready(s16_ir),
    .A(s16_a), .B(s16_b), .cin(sw_cin), .sub(sw_sub), .out_valid(s16_ov), .out_ready(sw_ordy),
    .Sum(s16_s), .Carry(s16_c), .Ovf(s16_o)
  );

  pipelined_carry_adder #(.WIDTH(8), .STAGES(2)) u8x2 (
    .clk(clk), .rst_n(rst_n), .in_valid(s8_iv), .in_ready(s8_ir),
    .A(s8_a), .B(s8_b), .cin(sw_cin), .sub(sw_sub), .out_valid(s8_ov), .out_ready(sw_ordy),
    .Sum(s8_s), .Carry(s8_c), .Ovf(s8_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Golden model: {Ovf, Carry, Sum} from wide arithmetic.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic c, input logic s);
    logic [31:0] bp;
    logic [32:0] full;
    logic        ovf;
    bp   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bp} + {32'd0, (s ? 1'b1 : c)};
    ovf  = (a[31] == bp[31]) && (full[31] != a[31]);
    return {ovf, full};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampling on the falling edge ahead of each transfer edge.
  initial begin
    logic [33:0] exp_v;
    stall_q   = 1'b0;
    stall_val = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        stall_q = 1'b0;
      end else begin
        if (stall_q) check("stall_hold", {Ovf, Carry, Sum}, stall_val);
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check("spurious_out", out_valid, 1'b0);
          end else begin
            exp_v = sb_q.pop_front();
            check("result", {Ovf, Carry, Sum}, exp_v);
          end
        end
        if (in_valid && in_ready) sb_q.push_back(model(A, B, cin, sub));
        stall_q   = out_valid && !out_ready;
        stall_val = {Ovf, Carry, Sum};
      end
    end
  end

  task automatic single(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input logic s, input logic [33:0] exp);
    A = a; B = b; cin = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check("lat_early", out_valid, 1'b0);
      step();
    end
    check("lat_valid", out_valid, 1'b1);
    check("single_res", {Ovf, Carry, Sum}, exp);
    step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    check("drain_empty", sb_q.size(), 0);
  endtask

  initial begin
    int          issued;
    logic        got;
    int          lat1, lat16, lat8;
    logic [17:0] cap1, cap16;
    logic [9:0]  cap8;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; cin = 1'b0; sub = 1'b0;
    sw_cin = 1'b0; sw_sub = 1'b0; sw_ordy = 1'b1;
    s1_iv = 1'b0; s16_iv = 1'b0; s8_iv = 1'b0;
    s1_a = '0; s1_b = '0; s16_a = '0; s16_b = '0; s8_a = '0; s8_b = '0;
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", Sum, 32'd0);
    check("rst_carry", Carry, 1'b0);
    check("rst_ovf", Ovf, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);

    single(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
    single(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
    single(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
    single(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});
    single(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
    drain();

    // Back-to-back random stream.
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      A = $urandom; B = $urandom;
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      #1;
      check("stream_in_ready", in_ready, 1'b1);
      step();
      check("stream_out_valid", out_valid, (i >= 3));
    end
    drain();

    // Backpressure: output stalled for six cycles mid-stream.
    issued = 0;
    for (int cyc = 0; cyc < 40 && issued < 10; cyc++) begin
      out_ready = !(cyc >= 2 && cyc < 8);
      in_valid = 1'b1;
      A = $urandom; B = $urandom;
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      #1;
      if (cyc >= 4 && cyc < 8) check("bp_in_ready_low", in_ready, 1'b0);
      got = in_ready;
      step();
      if (got) issued++;
    end
    check("bp_issued", issued, 10);
    drain();

    // Reset with three operations in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      A = $urandom; B = $urandom; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_sum", Sum, 32'd0);
    check("mid_rst_carry", Carry, 1'b0);
    check("mid_rst_ovf", Ovf, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("mid_rst_no_out", out_valid, 1'b0);
    end

    // Parameter sweep: signed overflow and exact latency.
    s1_a = 16'h7FFF; s1_b = 16'h0001; s16_a = 16'h7FFF; s16_b = 16'h0001;
    s8_a = 8'h7F; s8_b = 8'h01;
    s1_iv = 1'b1; s16_iv = 1'b1; s8_iv = 1'b1;
    step();
    s1_iv = 1'b0; s16_iv = 1'b0; s8_iv = 1'b0;
    lat1 = 0; lat16 = 0; lat8 = 0;
    cap1 = '0; cap16 = '0; cap8 = '0;
    for (int c = 1; c <= 24; c++) begin
      if (s1_ov && lat1 == 0) begin lat1 = c; cap1 = {s1_o, s1_c, s1_s}; end
      if (s16_ov && lat16 == 0) begin lat16 = c; cap16 = {s16_o, s16_c, s16_s}; end
      if (s8_ov && lat8 == 0) begin lat8 = c; cap8 = {s8_o, s8_c, s8_s}; end
      step();
    end
    check("sw16x1_lat", lat1, 1);
    check("sw16x1_res", cap1, {1'b1, 1'b0, 16'h8000});
    check("sw16x16_lat", lat16, 16);
    check("sw16x16_res", cap16, {1'b1, 1'b0, 16'h8000});
    check("sw8x2_lat", lat8, 2);
    check("sw8x2_res", cap8, {1'b1, 1'b0, 8'h80});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
